// File: rtl/fifo_pkg.sv
// Shared types and defaults for the single-clock FIFO family.
package fifo_pkg;

   typedef enum logic {
      FIFO_STD  = 1'b0,
      FIFO_FWFT = 1'b1
   } fifo_mode_e;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_ADDR_WIDTH = 6;

   function automatic int fifo_depth(input int addr_width);
      return 1 << addr_width;
   endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Flop-array storage for sync_fifo: synchronous write port, read port
// registered (STD) or combinational (FWFT) depending on MODE.
module sync_fifo_mem
   import fifo_pkg::*;
#(
   parameter int         DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int         ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter fifo_mode_e MODE       = FIFO_STD
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic                  re_i,
   input  logic [ADDR_WIDTH-1:0] raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   localparam int DEPTH = fifo_depth(ADDR_WIDTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   // Storage is intentionally left unreset; only the read register is cleared.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   generate
      if (MODE == FIFO_FWFT) begin : g_fwft
         logic unused_fwft;
         assign unused_fwft = re_i ^ rst_n;
         assign rdata_o     = mem_q[raddr_i];
      end else begin : g_std
         logic [DATA_WIDTH-1:0] rdata_q;
         logic [DATA_WIDTH-1:0] rdata_d;

         always_comb begin
            rdata_d = rdata_q;
            if (re_i) begin
               rdata_d = mem_q[raddr_i];
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               rdata_q <= '0;
            end else begin
               rdata_q <= rdata_d;
            end
         end

         assign rdata_o = rdata_q;
      end
   endgenerate

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointer/count/flag/sticky-error logic around
// sync_fifo_mem, with selectable STD or first-word-fall-through read.
module sync_fifo
   import fifo_pkg::*;
#(
   parameter int         DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int         ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter fifo_mode_e MODE       = FIFO_STD,
   parameter int         AFULL_TH   = 56,
   parameter int         AEMPTY_TH  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow,
   input  logic                  clr_err
);

   localparam int               DEPTH    = fifo_depth(ADDR_WIDTH);
   localparam int               PTR_W    = ADDR_WIDTH + 1;
   localparam logic [PTR_W-1:0] DEPTH_C  = PTR_W'(DEPTH);
   localparam logic [PTR_W-1:0] AFULL_C  = PTR_W'(AFULL_TH);
   localparam logic [PTR_W-1:0] AEMPTY_C = PTR_W'(AEMPTY_TH);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
      $fatal(1, "sync_fifo: AFULL_TH=%0d outside 1..%0d", AFULL_TH, DEPTH);
   end
   if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_bad_aempty
      $fatal(1, "sync_fifo: AEMPTY_TH=%0d outside 0..%0d", AEMPTY_TH, DEPTH - 1);
   end

   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic             ovf_q, ovf_d;
   logic             udf_q, udf_d;
   logic [PTR_W-1:0] occ;
   logic             is_full, is_empty;
   logic             wr_acc, rd_acc;

   // Everything below decodes registered pointers, so no flag sees wr_en/rd_en.
   assign occ      = wptr_q - rptr_q;
   assign is_full  = (occ == DEPTH_C);
   assign is_empty = (occ == '0);

   assign wr_acc = wr_en && !is_full  && !flush;
   assign rd_acc = rd_en && !is_empty && !flush;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      ovf_d  = ovf_q;
      udf_d  = udf_q;

      if (flush) begin
         wptr_d = '0;
         rptr_d = '0;
      end else begin
         if (wr_acc) begin
            wptr_d = wptr_q + PTR_ONE;
         end
         if (rd_acc) begin
            rptr_d = rptr_q + PTR_ONE;
         end
      end

      // A coincident set event overrides clr_err.
      if (clr_err) begin
         ovf_d = 1'b0;
         udf_d = 1'b0;
      end
      if (!flush && wr_en && is_full) begin
         ovf_d = 1'b1;
      end
      if (!flush && rd_en && is_empty) begin
         udf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
         ovf_q  <= 1'b0;
         udf_q  <= 1'b0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         ovf_q  <= ovf_d;
         udf_q  <= udf_d;
      end
   end

   sync_fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .MODE       (MODE)
   ) u_mem (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_i    (wr_acc),
      .waddr_i (wptr_q[ADDR_WIDTH-1:0]),
      .wdata_i (data_in),
      .re_i    (rd_acc),
      .raddr_i (rptr_q[ADDR_WIDTH-1:0]),
      .rdata_o (data_out)
   );

   assign full         = is_full;
   assign empty        = is_empty;
   assign almost_full  = (occ >= AFULL_C);
   assign almost_empty = (occ <= AEMPTY_C);
   assign count        = occ;
   assign overflow     = ovf_q;
   assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: one STD and one FWFT instance share stimulus.
module tb_sync_fifo;
   import fifo_pkg::*;

   logic       clk     = 1'b0;
   logic       rst_n   = 1'b1;
   logic       flush   = 1'b0;
   logic       wr_en   = 1'b0;
   logic       rd_en   = 1'b0;
   logic       clr_err = 1'b0;
   logic [7:0] data_in = 8'h00;

   logic [7:0] s_dout, f_dout;
   logic [6:0] s_count, f_count;
   logic       s_full, s_empty, s_afull, s_aempty, s_ovf, s_udf;
   logic       f_full, f_empty, f_afull, f_aempty, f_ovf, f_udf;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   sync_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .MODE(FIFO_STD),
               .AFULL_TH(56), .AEMPTY_TH(8)) u_std (
      .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .data_in(data_in),
      .rd_en(rd_en), .data_out(s_dout), .full(s_full), .empty(s_empty),
      .almost_full(s_afull), .almost_empty(s_aempty), .count(s_count),
      .overflow(s_ovf), .underflow(s_udf), .clr_err(clr_err)
   );

   sync_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .MODE(FIFO_FWFT),
               .AFULL_TH(56), .AEMPTY_TH(8)) u_fwft (
      .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .data_in(data_in),
      .rd_en(rd_en), .data_out(f_dout), .full(f_full), .empty(f_empty),
      .almost_full(f_afull), .almost_empty(f_aempty), .count(f_count),
      .overflow(f_ovf), .underflow(f_udf), .clr_err(clr_err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] q[$];
   logic [7:0] exp_d;
   logic       w, r, wacc, racc;
   int         n;

   initial begin
      // Reset
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_count", s_count, 0);
      chk("rst_empty", s_empty, 1);
      chk("rst_full", s_full, 0);
      chk("rst_aempty", s_aempty, 1);
      chk("rst_afull", s_afull, 0);
      chk("rst_ovf", s_ovf, 0);
      chk("rst_udf", s_udf, 0);
      chk("rst_dout", s_dout, 0);
      rst_n = 1'b1;
      tick();

      // Fill 0x00..0x3F
      wr_en = 1'b1;
      for (int i = 0; i < 64; i++) begin
         data_in = 8'(i);
         tick();
         chk("fill_count", s_count, i + 1);
         if (i == 54) chk("afull_at55", s_afull, 0);
         if (i == 55) chk("afull_at56", s_afull, 1);
         if (i == 62) chk("full_at63", s_full, 0);
      end
      chk("fill_full", s_full, 1);
      chk("fill_ovf_clear", s_ovf, 0);
      data_in = 8'hFF;
      tick();
      wr_en = 1'b0;
      chk("ovf_set", s_ovf, 1);
      chk("ovf_count", s_count, 64);

      // Drain STD
      rd_en = 1'b1;
      for (int i = 0; i < 64; i++) begin
         tick();
         chk("drain_data", s_dout, i);
         chk("drain_count", s_count, 63 - i);
         if (i == 54) chk("aempty_at9", s_aempty, 0);
         if (i == 55) chk("aempty_at8", s_aempty, 1);
      end
      chk("drain_empty", s_empty, 1);
      tick();
      chk("udf_set", s_udf, 1);
      chk("udf_hold_dout", s_dout, 8'h3F);
      chk("udf_count", s_count, 0);
      chk("ovf_sticky", s_ovf, 1);
      rd_en = 1'b0; clr_err = 1'b1;
      tick();
      chk("clr_udf", s_udf, 0);
      chk("clr_ovf", s_ovf, 0);
      rd_en = 1'b1;
      tick();
      chk("set_wins", s_udf, 1);
      rd_en = 1'b0;
      tick();
      clr_err = 1'b0;
      chk("clr_again", s_udf, 0);

      // Simultaneous write+read at empty, then at full
      wr_en = 1'b1; rd_en = 1'b1; data_in = 8'h11;
      tick();
      chk("wr_rd_empty_cnt", s_count, 1);
      chk("wr_rd_empty_udf", s_udf, 1);
      chk("wr_rd_empty_ovf", s_ovf, 0);
      rd_en = 1'b0; wr_en = 1'b0; clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      wr_en = 1'b1;
      for (int i = 0; i < 63; i++) begin
         data_in = 8'(8'h40 + i);
         tick();
      end
      chk("refill_full", s_full, 1);
      rd_en = 1'b1; data_in = 8'hEE;
      tick();
      wr_en = 1'b0;
      chk("wr_rd_full_cnt", s_count, 63);
      chk("wr_rd_full_ovf", s_ovf, 1);
      chk("wr_rd_full_data", s_dout, 8'h11);
      chk("wr_rd_full_flag", s_full, 0);
      for (int i = 0; i < 63; i++) begin
         tick();
         chk("redrain_data", s_dout, 8'h40 + i);
      end
      rd_en = 1'b0;
      chk("redrain_empty", s_empty, 1);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;

      // Random interleaved traffic against a queue model
      for (int i = 0; i < 200; i++) begin
         w = ($urandom_range(0, 9) < 6);
         r = ($urandom_range(0, 9) < 5);
         wr_en = w; rd_en = r; data_in = 8'($urandom_range(0, 255));
         wacc = w && (q.size() < 64);
         racc = r && (q.size() > 0);
         if (racc) exp_d = q.pop_front();
         if (wacc) q.push_back(data_in);
         tick();
         if (racc) chk("rand_data", s_dout, exp_d);
         chk("rand_count", s_count, q.size());
         chk("rand_fwft_count", f_count, q.size());
         if (s_count > 64) chk("rand_cnt_max", s_count, 64);
      end
      wr_en = 1'b0;
      n = q.size();
      for (int i = 0; i < n; i++) begin
         rd_en = 1'b1;
         exp_d = q.pop_front();
         tick();
         chk("rand_drain", s_dout, exp_d);
      end
      rd_en = 1'b0; clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      chk("rand_end_empty", s_empty, 1);

      // FWFT behaviour
      wr_en = 1'b1; data_in = 8'hA5;
      tick();
      wr_en = 1'b0;
      chk("fwft_empty_lo", f_empty, 0);
      chk("fwft_head", f_dout, 8'hA5);
      tick();
      chk("fwft_head_hold", f_dout, 8'hA5);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      chk("fwft_pop_empty", f_empty, 1);
      chk("std_shadow_a5", s_dout, 8'hA5);
      wr_en = 1'b1; data_in = 8'h5A;
      tick();
      data_in = 8'h3C;
      tick();
      wr_en = 1'b0;
      chk("fwft_head2", f_dout, 8'h5A);
      rd_en = 1'b1;
      tick();
      chk("fwft_next", f_dout, 8'h3C);
      chk("fwft_cnt1", f_count, 1);
      tick();
      chk("fwft_empty2", f_empty, 1);
      chk("std_shadow_3c", s_dout, 8'h3C);

      // Flush with stored words, sticky flag present
      tick();
      rd_en = 1'b0;
      chk("pre_flush_udf", s_udf, 1);
      wr_en = 1'b1;
      for (int i = 0; i < 10; i++) begin
         data_in = 8'(8'h80 + i);
         tick();
      end
      chk("pre_flush_cnt", s_count, 10);
      flush = 1'b1; data_in = 8'h99;
      tick();
      flush = 1'b0; wr_en = 1'b0;
      chk("flush_cnt", s_count, 0);
      chk("flush_empty", s_empty, 1);
      chk("flush_udf_kept", s_udf, 1);
      chk("flush_dout_kept", s_dout, 8'h3C);
      wr_en = 1'b1; data_in = 8'h77;
      tick();
      wr_en = 1'b0;
      chk("post_flush_cnt", s_count, 1);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      chk("post_flush_data", s_dout, 8'h77);

      // Asynchronous reset mid-stream
      wr_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         data_in = 8'(i + 1);
         tick();
      end
      chk("pre_rst_cnt", s_count, 5);
      rst_n = 1'b0;
      #2;
      chk("arst_cnt", s_count, 0);
      chk("arst_empty", s_empty, 1);
      chk("arst_udf", s_udf, 0);
      chk("arst_dout", s_dout, 0);
      chk("arst_fwft_empty", f_empty, 1);
      wr_en = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      tick();
      chk("post_rst_cnt", s_count, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
